// File: rtl/scmem_pkg.sv
// scmem_pkg: shared helpers for the scmem elastic buffer bank
package scmem_pkg;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_chan.sv
// elastic_chan: one valid/retry elastic channel with flop-array buffer, flush and optional bypass
module elastic_chan
  import scmem_pkg::*;
#(
  parameter int SIZE   = 64,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 0,
  parameter int OCCW   = occ_width(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [SIZE-1:0] din,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [SIZE-1:0] q,
  output logic            qValid,
  input  logic            qRetry,
  output logic [OCCW-1:0] occ
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [OCCW-1:0] FULL = OCCW'(DEPTH);

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [OCCW-1:0] cnt;
  logic            empty, pass, push, store, pop;

  // handshake decode; dinRetry depends only on the count register and flush
  always_comb begin
    empty    = cnt == '0;
    pass     = (BYPASS != 0) && empty;
    dinRetry = (cnt == FULL) | flush;
    qValid   = pass ? dinValid & ~flush : ~empty;
    q        = pass ? din : mem[rd_ptr];
    push     = dinValid & ~dinRetry;
    store    = push & ~(pass & ~qRetry);
    pop      = ~empty & ~qRetry;
  end

  // pointers and count; flush and reset both drop every entry
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + OCCW'(store) - OCCW'(pop);
    end
  end

  // payload storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= din;
  end

  assign occ = cnt;

endmodule

// File: rtl/elastic_chan_bank.sv
// elastic_chan_bank: NCH independent elastic channels sliced out of packed ports
module elastic_chan_bank
  import scmem_pkg::*;
#(
  parameter int SIZE   = 64,
  parameter int DEPTH  = 2,
  parameter int NCH    = 4,
  parameter int BYPASS = 0,
  parameter int OCCW   = occ_width(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      flush,
  input  logic [NCH*SIZE-1:0] din,
  input  logic [NCH-1:0]      dinValid,
  output logic [NCH-1:0]      dinRetry,
  output logic [NCH*SIZE-1:0] q,
  output logic [NCH-1:0]      qValid,
  input  logic [NCH-1:0]      qRetry,
  output logic [NCH*OCCW-1:0] occ
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    elastic_chan #(
      .SIZE(SIZE),
      .DEPTH(DEPTH),
      .BYPASS(BYPASS),
      .OCCW(OCCW)
    ) u_chan (
      .clk(clk),
      .reset(reset),
      .flush(flush[i]),
      .din(din[i*SIZE +: SIZE]),
      .dinValid(dinValid[i]),
      .dinRetry(dinRetry[i]),
      .q(q[i*SIZE +: SIZE]),
      .qValid(qValid[i]),
      .qRetry(qRetry[i]),
      .occ(occ[i*OCCW +: OCCW])
    );
  end

endmodule

// File: tb/tb_elastic_chan_bank.sv
// tb_elastic_chan_bank: registered and bypass banks checked against a queue model plus literal scenarios
module tb_elastic_chan_bank;

  localparam int SIZE = 8, DEPTH = 4, NCH = 2, OCCW = 3;

  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic [1:0][NCH-1:0]      fl, dv, qr, dr, qv, xf;
  logic [1:0][NCH*SIZE-1:0] di, qo;
  logic [1:0][NCH*OCCW-1:0] oc;
  int checks = 0, failures = 0;
  bit ready = 0;
  logic [SIZE-1:0] mq [4][$];

  elastic_chan_bank #(.SIZE(SIZE), .DEPTH(DEPTH), .NCH(NCH), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .flush(fl[0]), .din(di[0]), .dinValid(dv[0]), .dinRetry(dr[0]),
    .q(qo[0]), .qValid(qv[0]), .qRetry(qr[0]), .occ(oc[0]));

  elastic_chan_bank #(.SIZE(SIZE), .DEPTH(DEPTH), .NCH(NCH), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .flush(fl[1]), .din(di[1]), .dinValid(dv[1]), .dinRetry(dr[1]),
    .q(qo[1]), .qValid(qv[1]), .qRetry(qr[1]), .occ(oc[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // model: each channel is a FIFO of at most DEPTH items; bypass lets an item skip an empty FIFO
  always @(negedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 4; n++) mq[n].delete();
      ready = 1;
    end else if (ready) begin
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCH; c++) begin
          int n, sz;
          logic v, f, r, edr, eqv, push, pop;
          logic [SIZE-1:0] d, eq;
          n   = b * 2 + c;
          sz  = mq[n].size();
          d   = di[b][c*SIZE +: SIZE];
          v   = dv[b][c];
          f   = fl[b][c];
          r   = qr[b][c];
          edr = (sz == DEPTH) || f;
          eqv = (sz != 0) || (b == 1 && v && !f);
          eq  = (sz != 0) ? mq[n][0] : d;
          chk($sformatf("model dinRetry b%0d c%0d", b, c), 32'(dr[b][c]), 32'(edr));
          chk($sformatf("model qValid b%0d c%0d", b, c), 32'(qv[b][c]), 32'(eqv));
          chk($sformatf("model occ b%0d c%0d", b, c), 32'(oc[b][c*OCCW +: OCCW]), 32'(sz));
          if (eqv) chk($sformatf("model q b%0d c%0d", b, c), 32'(qo[b][c*SIZE +: SIZE]), 32'(eq));
          push = v && !edr;
          pop  = eqv && !r;
          if (f) mq[n].delete();
          else if (!(sz == 0 && push && pop)) begin
            if (pop) void'(mq[n].pop_front());
            if (push) mq[n].push_back(d);
          end
        end
      end
    end
  end

  initial begin
    fl = '0; dv = '0; qr = '0; di = '0;
    repeat (3) tick;
    reset = 1;
    // back-pressure fill of ch0, then ordered drain
    qr[0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      di[0][7:0] = 8'(8'h11 * (k + 1));
      dv[0][0] = 1;
      tick;
    end
    dv[0][0] = 0;
    @(negedge clk);
    chk("fill dinRetry", 32'(dr[0][0]), 1);
    chk("fill occ0", 32'(oc[0][2:0]), 4);
    chk("fill occ1 idle", 32'(oc[0][5:3]), 0);
    tick;
    qr[0][0] = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain qValid", 32'(qv[0][0]), 1);
      chk("drain q", 32'(qo[0][7:0]), 32'(8'(8'h11 * (k + 1))));
      tick;
    end
    @(negedge clk);
    chk("drain empty", 32'(qv[0][0]), 0);
    tick;
    qr[0] = 2'b00;
    // streaming 0x00..0x0F with no bubbles
    for (int k = 0; k < 16; k++) begin
      di[0][7:0] = 8'(k);
      dv[0][0] = 1;
      @(negedge clk);
      chk("stream dinRetry", 32'(dr[0][0]), 0);
      if (k > 0) begin
        chk("stream q", 32'(qo[0][7:0]), 32'(k - 1));
        chk("stream occ", 32'(oc[0][2:0]), 1);
      end
      tick;
    end
    dv[0][0] = 0;
    @(negedge clk);
    chk("stream last", 32'(qo[0][7:0]), 32'h0f);
    tick;
    // flush with three stored items
    qr[0][0] = 1;
    for (int k = 0; k < 3; k++) begin
      di[0][7:0] = 8'(8'h31 + k);
      dv[0][0] = 1;
      tick;
    end
    fl[0][0] = 1;
    di[0][7:0] = 8'h99;
    qr[0][0] = 0;
    @(negedge clk);
    chk("flush dinRetry", 32'(dr[0][0]), 1);
    chk("flush head", 32'(qo[0][7:0]), 32'h31);
    chk("flush occ before", 32'(oc[0][2:0]), 3);
    tick;
    fl[0][0] = 0;
    dv[0][0] = 0;
    @(negedge clk);
    chk("flush occ after", 32'(oc[0][2:0]), 0);
    chk("flush qValid after", 32'(qv[0][0]), 0);
    tick;
    // bypass pass-through, then stored under retry
    di[1][7:0] = 8'hA5;
    dv[1][0] = 1;
    @(negedge clk);
    chk("byp q", 32'(qo[1][7:0]), 32'ha5);
    chk("byp qValid", 32'(qv[1][0]), 1);
    chk("byp occ", 32'(oc[1][2:0]), 0);
    tick;
    dv[1][0] = 0;
    @(negedge clk);
    chk("byp occ after", 32'(oc[1][2:0]), 0);
    tick;
    qr[1][0] = 1;
    dv[1][0] = 1;
    tick;
    dv[1][0] = 0;
    @(negedge clk);
    chk("byp stored occ", 32'(oc[1][2:0]), 1);
    chk("byp stored q", 32'(qo[1][7:0]), 32'ha5);
    tick;
    qr[1][0] = 0;
    @(negedge clk);
    chk("byp deliver", 32'(qv[1][0]), 1);
    tick;
    @(negedge clk);
    chk("byp drained", 32'(oc[1][2:0]), 0);
    tick;
    // mid-stream reset
    qr[0][1] = 1;
    for (int k = 0; k < 2; k++) begin
      di[0][15:8] = 8'(8'h51 + k);
      dv[0][1] = 1;
      tick;
    end
    dv[0][1] = 0;
    @(negedge clk);
    chk("pre-reset occ1", 32'(oc[0][5:3]), 2);
    tick;
    reset = 0;
    tick;
    reset = 1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk("reset qValid", 32'(qv[b]), 0);
      chk("reset dinRetry", 32'(dr[b]), 0);
      chk("reset occ", 32'(oc[b]), 0);
    end
    tick;
    qr[0][1] = 0;
    di[0][15:8] = 8'h5A;
    dv[0][1] = 1;
    tick;
    dv[0][1] = 0;
    @(negedge clk);
    chk("post-reset q", 32'(qo[0][15:8]), 32'h5a);
    chk("post-reset occ", 32'(oc[0][5:3]), 1);
    tick;
    // full channel with simultaneous pop and push
    qr[0][0] = 1;
    for (int k = 0; k < 4; k++) begin
      di[0][7:0] = 8'(8'h61 + k);
      dv[0][0] = 1;
      tick;
    end
    di[0][7:0] = 8'h65;
    qr[0][0] = 0;
    @(negedge clk);
    chk("full pop dinRetry", 32'(dr[0][0]), 1);
    chk("full pop occ", 32'(oc[0][2:0]), 4);
    tick;
    @(negedge clk);
    chk("full freed dinRetry", 32'(dr[0][0]), 0);
    chk("full freed occ", 32'(oc[0][2:0]), 3);
    tick;
    dv[0][0] = 0;
    qr[0][0] = 1;
    @(negedge clk);
    chk("full push taken occ", 32'(oc[0][2:0]), 3);
    chk("full head", 32'(qo[0][7:0]), 32'h63);
    tick;
    // randomized traffic, producer holds valid and payload until transfer
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      xf = dv & ~dr;
      @(posedge clk);
      #1;
      reset = $urandom_range(0, 199) != 0;
      for (int b = 0; b < 2; b++) begin
        for (int c = 0; c < NCH; c++) begin
          if (!dv[b][c] || xf[b][c]) begin
            dv[b][c] = $urandom_range(0, 3) != 0;
            di[b][c*SIZE +: SIZE] = 8'($urandom);
          end
          qr[b][c] = $urandom_range(0, 9) < (((t / 250) % 2) != 0 ? 7 : 2);
          fl[b][c] = $urandom_range(0, 29) == 0;
        end
      end
    end
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_chan_bank.md
# elastic_chan_bank

Parametrised bank of NCH independent valid/retry elastic buffers, each DEPTH entries deep and SIZE bits wide. It is the multi-channel, configurable-depth successor to the single-entry fflop retiming stage. It sits between the directory bank and its L2/memory channels. It cuts every combinational path between producer and consumer, and adds occupancy reporting, synchronous flush and an optional zero-latency bypass mode.

## Interface
- SIZE, 64: payload width per channel, in bits (≥1).
- DEPTH, 2: entries per channel. Power of two, ≥2.
- NCH, 4: number of independent channels (≥1).
- BYPASS, 0: 0 = fully registered (latency 1); 1 = an empty channel passes din to q combinationally (latency 0).
- OCCW, $clog2(DEPTH+1): occupancy counter width (derived).
- clk  in  1  the single clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-low reset; state clears on a clk edge where reset==0.
- flush  in  NCH  per-channel synchronous discard of all entries.
- din  in  NCH*SIZE  payloads; channel i is din[i*SIZE +: SIZE].
- dinValid  in  NCH  producer valid.
- dinRetry  out  NCH  producer back-pressure.
- q  out  NCH*SIZE  head payload; channel packing is the same as din.
- qValid  out  NCH  head valid.
- qRetry  in  NCH  consumer back-pressure.
- occ  out  NCH*OCCW  per-channel entry count, registered.

## Operation
- A transfer occurs on an edge where valid==1 and retry==0. Valid must hold until transferred. Payload is stable while valid==1 and retry==1.
- Each channel is a circular buffer with a write pointer, a read pointer (log2(DEPTH) bits, wrapping DEPTH-1→0) and a count in the range 0..DEPTH.
- dinRetry[i] = (count==DEPTH) | flush[i]. The count term is driven from a register only, so there is no path from qRetry to dinRetry.
- qValid[i] = (count!=0) and q[i] = mem[rd_ptr].
- BYPASS=1 with count==0: qValid = dinValid and q = din.
  - If qRetry==0, the item passes through. Nothing is stored and no pointer moves.
  - If qRetry==1, the item is written to the buffer (count becomes 1).
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full channel with a pop in the same cycle: dinRetry stays 1 that cycle. The freed slot becomes visible on the next cycle.
- Flush cycle:
  - din is retried.
  - A pop that cycle is still honoured, so the head may be consumed.
  - At the edge, count=0 and both pointers return to 0. Memory contents are not cleared.
- Reset: count, pointers and occ are 0 for every channel. Memory is not reset.
- Reset state of outputs: qValid=0, dinRetry=0, occ=0, q=don't-care. In BYPASS=1, qValid and q follow din.
- Reset asserted mid-stream drops all entries. Nothing in flight is delivered after reset deasserts.
- Channels share no state. Activity on channel i never affects channel j.

## Timing
- BYPASS=0: an item accepted at edge t appears on q in cycle t+1. Sustained throughput is 1 per cycle per channel once DEPTH≥2.
- BYPASS=1: latency 0 when empty, otherwise 1.
- occ reflects the count after the most recent edge. A pass-through in bypass mode never changes occ.
- Back-pressure: with qRetry held at 1, a channel accepts exactly DEPTH items and then asserts dinRetry.

## Structure
- New in the scmem package: the function occ_width(depth) = $clog2(depth+1). There is no new typedef; instantiators cast channel structs such as I_drtol2_snack_type into din and out of q.
- One sub-module, elastic_chan: a single channel holding the buffer, pointers, count, and flush/bypass logic. The top level is a generate loop of NCH instances that slices the packed ports.
- The memory is a flop array indexed by pointer. No SRAM macro is used.

## Test plan
- SIZE=8, DEPTH=4, NCH=2, BYPASS=0, qRetry=1. Push 0x11,0x22,0x33,0x44 on ch0.
  - Required: dinRetry[0]=1 after the 4th push, occ[0]=4, ch1 idle with occ[1]=0.
  - Then release qRetry: q reads 0x11..0x44 in order, one per cycle.
- Streaming on ch0, dinValid and qRetry=0 every cycle, 16 items 0x00..0x0F:
  - Required: each item on q exactly one cycle after acceptance, zero bubbles, occ[0] constant at 1, pointers wrap cleanly.
- Fill ch0 to 3, then assert flush[0] with dinValid=1 and qRetry=0:
  - Required: din retried, head consumed that cycle, occ[0]=0 next cycle, qValid[0]=0.
- BYPASS=1, empty channel, din=0xA5 valid, qRetry=0:
  - Required: q=0xA5 and qValid=1 in the same cycle, occ stays 0.
  - Repeat with qRetry=1: the item is stored, occ becomes 1, and 0xA5 is delivered once qRetry drops.
- Fill ch1 with 2 items, then drive reset=0 for one edge:
  - Required: next cycle qValid=0, dinRetry=0, occ=0 on all channels; first post-reset push is delivered correctly.
- Full channel with simultaneous pop and dinValid=1:
  - Required: the push is retried that cycle, occ goes from DEPTH to DEPTH-1, and the push is accepted the following cycle.
